// File: rtl/sync_pkg.sv
// -----------------------------------------------------------------------------
// sync_pkg
//   Shared constants and helpers for the multi-channel bit synchronizer.
//   - MIN_STAGES : smallest synchronizer chain depth accepted by the top.
//   - clog2      : constant ceiling-log2 used for sizing counters.
//   - cnt_width  : glitch-filter counter width for a given FILTER_LEN,
//                  clog2(FILTER_LEN+1), never narrower than one bit so the
//                  declaration stays legal when the filter is bypassed.
// -----------------------------------------------------------------------------
package sync_pkg;

    localparam int MIN_STAGES = 2;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    function automatic int cnt_width(input int filter_len);
        int w;
        w = clog2(filter_len + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sync_filter_chan.sv
// -----------------------------------------------------------------------------
// sync_filter_chan
//   One channel of the synchronizer: a STAGES-deep flop chain, an optional
//   persistence filter on the chain output and registered edge pulses.
//
// Ports
//   clk       in   destination-domain clock
//   rst       in   synchronous, active-high reset
//   async_in  in   asynchronous source bit
//   sync_out  out  synchronized (and filtered) level, registered
//   rise      out  one-cycle pulse when sync_out goes 0 -> 1
//   fall      out  one-cycle pulse when sync_out goes 1 -> 0
// -----------------------------------------------------------------------------
module sync_filter_chan
    import sync_pkg::*;
#(
    parameter int   STAGES     = 2,
    parameter int   FILTER_LEN = 0,
    parameter logic RST_VAL    = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out,
    output logic rise,
    output logic fall
);

    // Metastability chain: kept together and away from retiming so the
    // resolution time between flops is preserved.
    (* ASYNC_REG = "TRUE", DONT_TOUCH = "TRUE" *) logic [STAGES-1:0] chain_q;
    logic [STAGES-1:0] chain_d;
    logic              s_last;

    logic sync_out_q;
    logic sync_out_d;
    logic rise_q;
    logic rise_d;
    logic fall_q;
    logic fall_d;

    always_comb begin
        chain_d = {chain_q[STAGES-2:0], async_in};
    end

    assign s_last = chain_q[STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            chain_q <= {STAGES{RST_VAL}};
        end else begin
            chain_q <= chain_d;
        end
    end

    generate
        if (FILTER_LEN == 0) begin : g_bypass
            always_comb begin
                sync_out_d = s_last;
            end
        end else begin : g_filter
            localparam int CNT_W = cnt_width(FILTER_LEN);
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;

            // cnt counts consecutive cycles the chain output has disagreed
            // with sync_out; the FILTER_LEN-th disagreeing cycle commits the
            // new level. Any agreeing cycle restarts the count.
            always_comb begin
                cnt_d      = '0;
                sync_out_d = sync_out_q;
                if (s_last != sync_out_q) begin
                    if (cnt_q == CNT_LAST) begin
                        sync_out_d = s_last;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end
    endgenerate

    // Pulses are computed from the next level so they register on the same
    // edge sync_out changes, and are mutually exclusive by construction.
    always_comb begin
        rise_d = sync_out_d & ~sync_out_q;
        fall_d = ~sync_out_d & sync_out_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_out_q <= RST_VAL;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
        end else begin
            sync_out_q <= sync_out_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
        end
    end

    assign sync_out = sync_out_q;
    assign rise     = rise_q;
    assign fall     = fall_q;

endmodule

// File: rtl/sync_filter_edge.sv
// -----------------------------------------------------------------------------
// sync_filter_edge
//   Multi-channel bit synchronizer for single-bit control/status signals
//   crossing into this clock domain, with optional glitch filter and
//   registered rise/fall pulses. Channels are independent: there is no
//   coherency between bits, so this is not for binary buses. Gray-coded
//   pointers may pass through only with FILTER_LEN = 0.
//
// Parameters
//   WIDTH       number of channels (>= 1)
//   STAGES      synchronizer flops per channel (>= 2)
//   FILTER_LEN  cycles a new level must persist before acceptance, 0 = bypass
//   RST_VAL     per-channel reset level of chain, filter and sync_out
//
// Ports
//   clk       in   destination-domain clock
//   rst       in   synchronous, active-high reset
//   async_in  in   [WIDTH] asynchronous source signals
//   sync_out  out  [WIDTH] synchronized level, registered
//   rise      out  [WIDTH] one-cycle pulse on accepted 0 -> 1
//   fall      out  [WIDTH] one-cycle pulse on accepted 1 -> 0
//   changed   out  any rise or fall this cycle
// -----------------------------------------------------------------------------
module sync_filter_edge
    import sync_pkg::*;
#(
    parameter int               WIDTH      = 1,
    parameter int               STAGES     = 2,
    parameter int               FILTER_LEN = 0,
    parameter logic [WIDTH-1:0] RST_VAL    = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);

    generate
        if (STAGES < MIN_STAGES) begin : g_bad_stages
            $error("sync_filter_edge: STAGES must be at least %0d", MIN_STAGES);
        end
        if (WIDTH < 1) begin : g_bad_width
            $error("sync_filter_edge: WIDTH must be at least 1");
        end
        if (FILTER_LEN < 0) begin : g_bad_filter
            $error("sync_filter_edge: FILTER_LEN must not be negative");
        end
    endgenerate

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        sync_filter_chan #(
            .STAGES     (STAGES),
            .FILTER_LEN (FILTER_LEN),
            .RST_VAL    (RST_VAL[i])
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .async_in (async_in[i]),
            .sync_out (sync_out[i]),
            .rise     (rise[i]),
            .fall     (fall[i])
        );
    end

    // Built from registered pulses only, so it is glitch-free in practice.
    assign changed = |(rise | fall);

endmodule
